seq_divider: RTL
================

# seq_divider

Parametrised iterative radix-2 restoring divider with valid/ready handshakes on both sides, per-operation signed/unsigned mode, and divide-by-zero detection. It replaces the fixed-width start/stop divider in the arithmetic datapath. It computes one quotient bit per cycle, stalls cleanly under output backpressure, and is the standard divide unit for HLS-generated datapaths.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation; high only in IDLE.
- dividend  in  WIDTH  numerator, sampled on accept.
- divisor  in  WIDTH  denominator, sampled on accept.
- signed_mode  in  1  1 means operands are two's complement; sampled on accept.
- out_valid  out  1  result registers hold a completed result.
- out_ready  in  1  consumer takes the result.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.
- div_by_zero  out  1  registered flag; the result came from a zero divisor.

## Operation
- Accept: in_valid && in_ready at a rising edge. The block latches the operand magnitudes, the quotient sign (sign(dividend) XOR sign(divisor) when signed_mode=1, else 0) and the remainder sign (sign(dividend) when signed_mode=1, else 0).
- Magnitude in signed mode is the two's-complement negate of a negative operand, kept as a WIDTH-bit unsigned value. The most negative value maps to 2^(WIDTH-1) with no special case.
- States:
  - IDLE: in_ready=1. On accept, go to ZERO if divisor==0, else go to CALC and load count=WIDTH and partial remainder=0.
  - CALC: each cycle, shift the partial remainder left and bring in the dividend MSB. Form trial = partial remainder − |divisor| at WIDTH+1 bits. If trial is non-negative, keep the trial value and shift in quotient bit 1; otherwise keep the shifted value and shift in quotient bit 0. Decrement count. When count reaches 1 this cycle, go to FIX.
  - FIX: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. Write quotient and remainder and set div_by_zero=0 and out_valid=1. Go to DONE.
  - ZERO: write quotient = all ones and remainder = the original dividend (the same in both modes). Set div_by_zero=1 and out_valid=1. Go to DONE.
  - DONE: out_valid=1 and the result is held stable. On out_ready, clear out_valid and go to IDLE.
- Result rules:
  - Signed division truncates toward zero; a nonzero remainder takes the sign of the dividend.
  - MIN / −1 gives quotient = MIN and remainder = 0, through natural wrap.
  - Unsigned mode: quotient = floor(dividend / divisor) and remainder = dividend mod divisor.
- Inputs are ignored whenever in_ready=0. out_ready is ignored whenever out_valid=0.
- Reset mid-operation (any state): the block returns to IDLE immediately. The in-flight operation is discarded and no out_valid is produced for it.

## Timing
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Normal latency: out_valid rises WIDTH+1 edges after the accept edge (WIDTH CALC cycles plus FIX).
- Divide-by-zero latency: out_valid rises 1 edge after the accept edge.
- Minimum handshake throughput: one operation per WIDTH+3 cycles. in_ready rises on the edge where out_valid && out_ready, so it does not overlap out_valid.
- Backpressure: with out_ready held low, the block stays in DONE indefinitely and quotient, remainder and div_by_zero do not change.
- All outputs are registered or decoded from the state register only. There is no combinational path from any input to any output.

## Test plan
- WIDTH=8, unsigned 100/7 (0x64/0x07): quotient 0x0E, remainder 0x02, div_by_zero 0, out_valid exactly 9 edges after accept.
- Signed −7/2 (0xF9/0x02): quotient 0xFD (−3), remainder 0xFF (−1). Signed 7/−2 (0x07/0xFE): quotient 0xFD, remainder 0x01.
- Signed −128/−1 (0x80/0xFF): quotient 0x80, remainder 0x00. The same operands unsigned (128/255): quotient 0x00, remainder 0x80.
- Divide by zero, 0x35/0x00, both modes: quotient 0xFF, remainder 0x35, div_by_zero 1, out_valid 1 edge after accept, in_ready low until the result drains.
- Backpressure and back-to-back: hold out_ready low for 20 cycles and check the result stays stable and in_ready stays 0. Assert out_ready, then issue a second operation (200/3 → quotient 0x42, remainder 0x02) on the first in_ready cycle. Check it is accepted and correct.
- Pulse reset_n low 4 cycles into CALC: all outputs return to reset values asynchronously. Check no stale out_valid appears, then a fresh 255/16 gives quotient 0x0F, remainder 0x0F.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider, one quotient bit per cycle.
// Valid/ready handshake on both sides, per-operation signed/unsigned mode,
// divide-by-zero detection.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     operand handshake (in_ready high only in IDLE)
//   dividend, divisor       WIDTH-bit operands, sampled on accept
//   signed_mode             1 = two's complement operands, sampled on accept
//   out_valid / out_ready   result handshake (result held while out_valid)
//   quotient, remainder     registered result
//   div_by_zero             registered flag, result came from a zero divisor
module seq_divider #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] count, count_n;
  // acc shifts the dividend out at the top and the quotient in at the bottom.
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] dvs, dvs_n;
  logic             q_neg, q_neg_n;
  logic             r_neg, r_neg_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic             div_by_zero_n;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             accept;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && (state == S_IDLE);

  // Operand magnitudes; the most negative value wraps to 2^(WIDTH-1) naturally.
  always_comb begin
    dvd_neg = signed_mode & dividend[WIDTH-1];
    dvs_neg = signed_mode & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? WIDTH'(~dividend + WIDTH'(1)) : dividend;
    dvs_mag = dvs_neg ? WIDTH'(~divisor + WIDTH'(1)) : divisor;
  end

  // One restoring step: bring in the next dividend bit and try a subtract.
  always_comb begin
    shifted = {rem, acc[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
  end

  // Next-state and datapath next values.
  always_comb begin
    state_n       = state;
    count_n       = count;
    acc_n         = acc;
    rem_n         = rem;
    dvs_n         = dvs;
    q_neg_n       = q_neg;
    r_neg_n       = r_neg;
    quotient_n    = quotient;
    remainder_n   = remainder;
    div_by_zero_n = div_by_zero;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          q_neg_n = dvd_neg ^ dvs_neg;
          r_neg_n = dvd_neg;
          dvs_n   = dvs_mag;
          rem_n   = '0;
          count_n = CNT_W'(WIDTH);
          if (divisor == '0) begin
            // Keep the raw dividend: a zero divisor returns it unchanged.
            acc_n   = dividend;
            state_n = S_ZERO;
          end else begin
            acc_n   = dvd_mag;
            state_n = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!trial[WIDTH]) begin
          rem_n = trial[WIDTH-1:0];
        end else begin
          rem_n = shifted[WIDTH-1:0];
        end
        acc_n   = {acc[WIDTH-2:0], ~trial[WIDTH]};
        count_n = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_n = S_FIX;
        end
      end

      S_FIX: begin
        quotient_n    = q_neg ? WIDTH'(~acc + WIDTH'(1)) : acc;
        remainder_n   = r_neg ? WIDTH'(~rem + WIDTH'(1)) : rem;
        div_by_zero_n = 1'b0;
        state_n       = S_DONE;
      end

      S_ZERO: begin
        quotient_n    = '1;
        remainder_n   = acc;
        div_by_zero_n = 1'b1;
        state_n       = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count       <= '0;
      acc         <= '0;
      rem         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      count       <= count_n;
      acc         <= acc_n;
      rem         <= rem_n;
      dvs         <= dvs_n;
      q_neg       <= q_neg_n;
      r_neg       <= r_neg_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= div_by_zero_n;
    end
  end

endmodule
